mult_issue_ctrl: RTL and testbench

Issue scheduler and result buffer for the 4-stage pipelined 64-bit multiplier.
- Arbitrates between two reservation-station issue ports for the single multiplier input slot, one op per cycle, round-robin.
- Tracks in-flight ops with credits so the result buffer can never overflow.
- Holds completed products in a FIFO until the CDB grants them.
- Applies branch recovery (squash and bmask clear) to buffered results.

---
 rtl/mult_issue_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_mult_issue_ctrl.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_issue_ctrl.sv
// Issue scheduler and result buffer for the 4-stage pipelined 64-bit multiplier.
// Round-robin issue of two requesters, credit flow control, result FIFO with branch recovery.
module mult_issue_ctrl #(
    parameter int DEPTH = 8,
    parameter int LAT   = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req0_valid,
    input  logic [63:0] req0_mplier,
    input  logic [63:0] req0_mcand,
    input  logic [5:0]  req0_dest,
    input  logic [3:0]  req0_bmask,
    input  logic [63:0] req0_npc,
    input  logic        req1_valid,
    input  logic [63:0] req1_mplier,
    input  logic [63:0] req1_mcand,
    input  logic [5:0]  req1_dest,
    input  logic [3:0]  req1_bmask,
    input  logic [63:0] req1_npc,
    output logic        gnt0,
    output logic        gnt1,
    output logic        mult_valid,
    output logic [63:0] mult_mplier,
    output logic [63:0] mult_mcand,
    output logic [5:0]  mult_dest,
    output logic [3:0]  mult_bmask,
    output logic [63:0] mult_npc,
    input  logic        mult_valid_out,
    input  logic [63:0] mult_product,
    input  logic [5:0]  mult_dest_out,
    input  logic [3:0]  mult_bmask_out,
    input  logic [63:0] mult_npc_out,
    input  logic        br_rec_en_1,
    input  logic        br_rec_en_2,
    input  logic [2:0]  br_marker_1,
    input  logic [2:0]  br_marker_2,
    input  logic        br_mispre_1,
    input  logic        br_mispre_2,
    output logic        cdb_req,
    input  logic        cdb_gnt,
    output logic [63:0] cdb_value,
    output logic [5:0]  cdb_dest,
    output logic [63:0] cdb_npc,
    output logic [3:0]  cdb_bmask,
    output logic [3:0]  mult_credits
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    function automatic logic [CW-1:0] f_ones(input logic [LAT-1:0] v);
        logic [CW-1:0] n;
        n = {CW{1'b0}};
        for (int i = 0; i < LAT; i++) begin
            n = n + CW'(v[i]);
        end
        return n;
    endfunction

    logic [LAT-1:0] r_shift;
    logic           r_rr;
    logic [AW-1:0]  r_head;
    logic [AW-1:0]  r_tail;
    logic [CW-1:0]  r_count;
    logic [63:0]    r_val [DEPTH];
    logic [5:0]     r_dst [DEPTH];
    logic [63:0]    r_npc [DEPTH];
    logic [3:0]     r_bm  [DEPTH];
    logic [DEPTH-1:0] r_sq;

    logic [CW-1:0]  w_credits;
    logic           w_can_issue;
    logic           w_gnt0;
    logic           w_gnt1;
    logic           w_issue;
    logic [3:0]     w_sel1;
    logic [3:0]     w_sel2;
    logic [3:0]     w_mis_mask;
    logic [3:0]     w_res_mask;
    logic           w_present;
    logic           w_head_hit;
    logic           w_cdb_req;
    logic           w_push;
    logic           w_pop;

    // Credits cover both in-flight ops and every buffered entry, so capture never overflows.
    assign w_credits   = CW'(DEPTH) - f_ones(r_shift) - r_count;
    assign w_can_issue = (w_credits != {CW{1'b0}});
    assign w_issue     = w_gnt0 | w_gnt1;

    assign w_sel1     = 4'b0001 << br_marker_1;
    assign w_sel2     = 4'b0001 << br_marker_2;
    assign w_mis_mask = ((br_rec_en_1 & br_mispre_1) ? w_sel1 : 4'b0000) |
                        ((br_rec_en_2 & br_mispre_2) ? w_sel2 : 4'b0000);
    assign w_res_mask = ((br_rec_en_1 & ~br_mispre_1) ? w_sel1 : 4'b0000) |
                        ((br_rec_en_2 & ~br_mispre_2) ? w_sel2 : 4'b0000);

    assign w_present  = (r_count != {CW{1'b0}});
    assign w_head_hit = |(r_bm[r_head] & w_mis_mask);
    assign w_cdb_req  = w_present & ~r_sq[r_head] & ~w_head_hit;
    assign w_push     = mult_valid_out;
    assign w_pop      = (w_cdb_req & cdb_gnt) | (w_present & r_sq[r_head]);

    // Round-robin arbitration between the two requesters.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (w_can_issue) begin
            if (req0_valid && req1_valid) begin
                if (r_rr) begin
                    w_gnt1 = 1'b1;
                end else begin
                    w_gnt0 = 1'b1;
                end
            end else if (req0_valid) begin
                w_gnt0 = 1'b1;
            end else if (req1_valid) begin
                w_gnt1 = 1'b1;
            end else begin
                w_gnt0 = 1'b0;
            end
        end else begin
            w_gnt1 = 1'b0;
        end
    end

    // Issue mux; requester 0 fields are presented whenever requester 1 is not granted.
    always_comb begin
        mult_mplier = req0_mplier;
        mult_mcand  = req0_mcand;
        mult_dest   = req0_dest;
        mult_bmask  = req0_bmask;
        mult_npc    = req0_npc;
        if (w_gnt1) begin
            mult_mplier = req1_mplier;
            mult_mcand  = req1_mcand;
            mult_dest   = req1_dest;
            mult_bmask  = req1_bmask;
            mult_npc    = req1_npc;
        end else begin
            mult_valid_dummy_keep();
        end
    end

    function automatic void mult_valid_dummy_keep();
    endfunction

    assign gnt0         = w_gnt0;
    assign gnt1         = w_gnt1;
    assign mult_valid   = w_issue;
    assign mult_credits = 4'(w_credits);

    assign cdb_req   = w_cdb_req;
    assign cdb_value = r_val[r_head];
    assign cdb_dest  = r_dst[r_head];
    assign cdb_npc   = r_npc[r_head];
    assign cdb_bmask = r_bm[r_head] & ~w_res_mask;

    // Issue shift register, arbitration pointer and FIFO pointers.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_shift <= {LAT{1'b0}};
            r_rr    <= 1'b0;
            r_head  <= {AW{1'b0}};
            r_tail  <= {AW{1'b0}};
            r_count <= {CW{1'b0}};
        end else begin
            r_shift <= {r_shift[LAT-2:0], w_issue};
            if (w_gnt0) begin
                r_rr <= 1'b1;
            end else if (w_gnt1) begin
                r_rr <= 1'b0;
            end else begin
                r_rr <= r_rr;
            end
            if (w_push) begin
                r_tail <= r_tail + AW'(1'b1);
            end else begin
                r_tail <= r_tail;
            end
            if (w_pop) begin
                r_head <= r_head + AW'(1'b1);
            end else begin
                r_head <= r_head;
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // Result storage: recovery on every entry, then capture at the tail with same-cycle recovery.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_sq <= {DEPTH{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                r_val[i] <= 64'd0;
                r_dst[i] <= 6'd0;
                r_npc[i] <= 64'd0;
                r_bm[i]  <= 4'd0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                r_bm[i] <= r_bm[i] & ~w_res_mask;
                r_sq[i] <= r_sq[i] | (|(r_bm[i] & w_mis_mask));
            end
            if (w_push) begin
                r_val[r_tail] <= mult_product;
                r_dst[r_tail] <= mult_dest_out;
                r_npc[r_tail] <= mult_npc_out;
                r_bm[r_tail]  <= mult_bmask_out & ~w_res_mask;
                r_sq[r_tail]  <= |(mult_bmask_out & w_mis_mask);
            end else begin
                r_sq[r_tail] <= r_sq[r_tail] | (|(r_bm[r_tail] & w_mis_mask));
            end
        end
    end

endmodule

// File: tb/tb_mult_issue_ctrl.sv
// Self-checking bench: multiplier pipeline stand-in plus a queue-based reference of the controller.
module tb_mult_issue_ctrl;
    localparam int DEPTH = 8;
    localparam int LAT   = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic [63:0] req0_mplier, req0_mcand, req0_npc, req1_mplier, req1_mcand, req1_npc;
    logic [5:0]  req0_dest, req1_dest;
    logic [3:0]  req0_bmask, req1_bmask;
    logic        gnt0, gnt1, mult_valid;
    logic [63:0] mult_mplier, mult_mcand, mult_npc;
    logic [5:0]  mult_dest;
    logic [3:0]  mult_bmask;
    logic        mult_valid_out;
    logic [63:0] mult_product, mult_npc_out;
    logic [5:0]  mult_dest_out;
    logic [3:0]  mult_bmask_out;
    logic        br_rec_en_1, br_rec_en_2, br_mispre_1, br_mispre_2;
    logic [2:0]  br_marker_1, br_marker_2;
    logic        cdb_req, cdb_gnt;
    logic [63:0] cdb_value, cdb_npc;
    logic [5:0]  cdb_dest;
    logic [3:0]  cdb_bmask;
    logic [3:0]  mult_credits;

    typedef struct packed {
        logic [63:0] v;
        logic [5:0]  d;
        logic [63:0] n;
        logic [3:0]  b;
        logic        sq;
    } ent_t;

    typedef struct packed {
        logic        occ;
        logic        val;
        logic [63:0] p;
        logic [5:0]  d;
        logic [3:0]  b;
        logic [63:0] n;
    } stg_t;

    ent_t q[$];
    stg_t pst [LAT];
    int   rr_m;
    int   n_tests = 0;
    int   n_fail  = 0;

    int          e_cred;
    logic        e_g0, e_g1, e_req;
    logic [63:0] e_val, e_npc;
    logic [5:0]  e_dst;
    logic [3:0]  e_bm, m_mis, m_res;

    always #5 clock = ~clock;

    assign mult_valid_out = pst[LAT-1].val;
    assign mult_product   = pst[LAT-1].p;
    assign mult_dest_out  = pst[LAT-1].d;
    assign mult_bmask_out = pst[LAT-1].b;
    assign mult_npc_out   = pst[LAT-1].n;

    mult_issue_ctrl #(.DEPTH(DEPTH), .LAT(LAT)) dut (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_mplier(req0_mplier), .req0_mcand(req0_mcand),
        .req0_dest(req0_dest), .req0_bmask(req0_bmask), .req0_npc(req0_npc),
        .req1_valid(req1_valid), .req1_mplier(req1_mplier), .req1_mcand(req1_mcand),
        .req1_dest(req1_dest), .req1_bmask(req1_bmask), .req1_npc(req1_npc),
        .gnt0(gnt0), .gnt1(gnt1), .mult_valid(mult_valid),
        .mult_mplier(mult_mplier), .mult_mcand(mult_mcand), .mult_dest(mult_dest),
        .mult_bmask(mult_bmask), .mult_npc(mult_npc),
        .mult_valid_out(mult_valid_out), .mult_product(mult_product),
        .mult_dest_out(mult_dest_out), .mult_bmask_out(mult_bmask_out), .mult_npc_out(mult_npc_out),
        .br_rec_en_1(br_rec_en_1), .br_rec_en_2(br_rec_en_2),
        .br_marker_1(br_marker_1), .br_marker_2(br_marker_2),
        .br_mispre_1(br_mispre_1), .br_mispre_2(br_mispre_2),
        .cdb_req(cdb_req), .cdb_gnt(cdb_gnt), .cdb_value(cdb_value), .cdb_dest(cdb_dest),
        .cdb_npc(cdb_npc), .cdb_bmask(cdb_bmask), .mult_credits(mult_credits)
    );

    // Expected combinational outputs from the reference state and the current inputs.
    task automatic expect_now();
        int occ;
        occ = 0;
        for (int k = 0; k < LAT; k++) occ += int'(pst[k].occ);
        e_cred = DEPTH - occ - q.size();
        m_mis = 4'b0000;
        m_res = 4'b0000;
        if (br_rec_en_1) begin
            if (br_mispre_1) m_mis = m_mis | (4'b0001 << br_marker_1);
            else             m_res = m_res | (4'b0001 << br_marker_1);
        end
        if (br_rec_en_2) begin
            if (br_mispre_2) m_mis = m_mis | (4'b0001 << br_marker_2);
            else             m_res = m_res | (4'b0001 << br_marker_2);
        end
        e_g0  = (e_cred > 0) && req0_valid && (!req1_valid || rr_m == 0);
        e_g1  = (e_cred > 0) && req1_valid && (!req0_valid || rr_m == 1);
        e_req = 1'b0;
        e_val = 64'd0; e_dst = 6'd0; e_npc = 64'd0; e_bm = 4'd0;
        if (q.size() > 0) begin
            e_req = !q[0].sq && ((q[0].b & m_mis) == 4'b0000);
            e_val = q[0].v; e_dst = q[0].d; e_npc = q[0].n;
            e_bm  = q[0].b & ~m_res;
        end
    endtask

    // Advance the reference by one clock edge using the inputs that were present before it.
    task automatic model_step();
        ent_t e;
        stg_t s;
        if (reset) begin
            q.delete();
            for (int k = 0; k < LAT; k++) pst[k] = '0;
            rr_m = 0;
            return;
        end
        expect_now();
        if (q.size() > 0) begin
            if (q[0].sq) void'(q.pop_front());
            else if (e_req && cdb_gnt) void'(q.pop_front());
        end
        foreach (q[i]) begin
            q[i].sq = q[i].sq | (|(q[i].b & m_mis));
            q[i].b  = q[i].b & ~m_res;
        end
        if (pst[LAT-1].val) begin
            e.v = pst[LAT-1].p; e.d = pst[LAT-1].d; e.n = pst[LAT-1].n;
            e.b = pst[LAT-1].b & ~m_res;
            e.sq = |(pst[LAT-1].b & m_mis);
            q.push_back(e);
        end
        for (int k = LAT - 1; k > 0; k--) begin
            pst[k] = pst[k-1];
            if ((pst[k].b & m_mis) != 4'b0000) pst[k].val = 1'b0;
            pst[k].b = pst[k].b & ~m_res;
        end
        s = '0;
        if (e_g0) begin
            s.occ = 1'b1; s.p = req0_mplier * req0_mcand; s.d = req0_dest; s.b = req0_bmask; s.n = req0_npc;
        end else if (e_g1) begin
            s.occ = 1'b1; s.p = req1_mplier * req1_mcand; s.d = req1_dest; s.b = req1_bmask; s.n = req1_npc;
        end
        s.val = s.occ && ((s.b & m_mis) == 4'b0000);
        s.b   = s.b & ~m_res;
        pst[0] = s;
        if (e_g0) rr_m = 1;
        else if (e_g1) rr_m = 0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        model_step();
    endtask

    task automatic idle();
        req0_valid = 1'b0; req1_valid = 1'b0;
        br_rec_en_1 = 1'b0; br_rec_en_2 = 1'b0; br_mispre_1 = 1'b0; br_mispre_2 = 1'b0;
        br_marker_1 = 3'd0; br_marker_2 = 3'd0;
        req0_mplier = {$urandom, $urandom}; req0_mcand = {$urandom, $urandom};
        req1_mplier = {$urandom, $urandom}; req1_mcand = {$urandom, $urandom};
        req0_dest = 6'($urandom); req1_dest = 6'($urandom);
        req0_bmask = 4'd0; req1_bmask = 4'd0;
        req0_npc = {$urandom, $urandom}; req1_npc = {$urandom, $urandom};
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle();
        cdb_gnt = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_tests++;
        if (gnt0 !== 1'b0 || gnt1 !== 1'b0 || mult_valid !== 1'b0 || cdb_req !== 1'b0)
            begin n_fail++; $display("FAIL reset_ctrl: gnt0=%b gnt1=%b mv=%b cdb_req=%b want all 0", gnt0, gnt1, mult_valid, cdb_req); end
        n_tests++;
        if (mult_credits !== 4'd8)
            begin n_fail++; $display("FAIL reset_credits: got %0d want 8", mult_credits); end
        n_tests++;
        if (cdb_value !== 64'd0 || cdb_dest !== 6'd0 || cdb_npc !== 64'd0 || cdb_bmask !== 4'd0)
            begin n_fail++; $display("FAIL reset_cdb_data: val=%h dest=%h npc=%h bm=%h want 0", cdb_value, cdb_dest, cdb_npc, cdb_bmask); end
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        n_tests++;
        if (gnt0 !== 1'b1 || gnt1 !== 1'b0)
            begin n_fail++; $display("FAIL reset_rr: gnt0=%b gnt1=%b want 1 0", gnt0, gnt1); end
        idle();
    endtask

    task automatic test_single();
        do_reset();
        cdb_gnt = 1'b1;
        req0_valid = 1'b1; req0_mplier = 64'd3; req0_mcand = 64'd5; req0_dest = 6'd7;
        #1;
        n_tests++;
        if (gnt0 !== 1'b1 || mult_valid !== 1'b1 || mult_mplier !== 64'd3 || mult_dest !== 6'd7)
            begin n_fail++; $display("FAIL single_issue: gnt0=%b mv=%b mplier=%0d dest=%0d want 1 1 3 7", gnt0, mult_valid, mult_mplier, mult_dest); end
        tick();
        for (int c = 2; c <= 6; c++) begin
            idle();
            #1;
            n_tests++;
            if (cdb_req !== (c == 6))
                begin n_fail++; $display("FAIL single_cdb_req c%0d: got %b want %b", c, cdb_req, (c == 6)); end
            if (c == 6) begin
                n_tests++;
                if (cdb_value !== 64'd15 || cdb_dest !== 6'd7)
                    begin n_fail++; $display("FAIL single_result: value=%0d dest=%0d want 15 7", cdb_value, cdb_dest); end
            end
            tick();
        end
        #1;
        n_tests++;
        if (cdb_req !== 1'b0 || mult_credits !== 4'd8)
            begin n_fail++; $display("FAIL single_after_pop: cdb_req=%b credits=%0d want 0 8", cdb_req, mult_credits); end
    endtask

    task automatic test_round_robin();
        logic [63:0] exp_q[$];
        do_reset();
        cdb_gnt = 1'b1;
        for (int i = 0; i < 4; i++) begin
            idle();
            req0_valid = 1'b1; req1_valid = 1'b1;
            exp_q.push_back((i % 2 == 0) ? req0_mplier * req0_mcand : req1_mplier * req1_mcand);
            #1;
            n_tests++;
            if (gnt0 !== (i % 2 == 0) || gnt1 !== (i % 2 == 1))
                begin n_fail++; $display("FAIL rr_order i%0d: gnt0=%b gnt1=%b want %b %b", i, gnt0, gnt1, (i % 2 == 0), (i % 2 == 1)); end
            tick();
        end
        for (int c = 0; c < 20; c++) begin
            idle();
            #1;
            if (cdb_req) begin
                n_tests++;
                if (exp_q.size() == 0 || cdb_value !== exp_q[0])
                    begin n_fail++; $display("FAIL rr_cdb_order: got %h want %h", cdb_value, (exp_q.size() > 0) ? exp_q[0] : 64'd0); end
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end
            tick();
        end
        n_tests++;
        if (exp_q.size() != 0)
            begin n_fail++; $display("FAIL rr_drain_timeout: %0d results missing want 0", exp_q.size()); end
    endtask

    task automatic test_backpressure();
        int grants;
        grants = 0;
        do_reset();
        cdb_gnt = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            idle();
            req0_valid = 1'b1;
            #1;
            if (gnt0 === 1'b1) grants++;
            tick();
        end
        n_tests++;
        if (grants != DEPTH)
            begin n_fail++; $display("FAIL bp_grants: got %0d want %0d", grants, DEPTH); end
        idle();
        req0_valid = 1'b1;
        cdb_gnt = 1'b1;
        #1;
        n_tests++;
        if (gnt0 !== 1'b0 || cdb_req !== 1'b1 || mult_credits !== 4'd0)
            begin n_fail++; $display("FAIL bp_full: gnt0=%b cdb_req=%b credits=%0d want 0 1 0", gnt0, cdb_req, mult_credits); end
        tick();
        #1;
        n_tests++;
        if (gnt0 !== 1'b1 || mult_credits !== 4'd1)
            begin n_fail++; $display("FAIL bp_resume: gnt0=%b credits=%0d want 1 1", gnt0, mult_credits); end
        tick();
        for (int c = 0; c < 20; c++) begin
            idle();
            tick();
        end
        #1;
        n_tests++;
        if (mult_credits !== 4'd8)
            begin n_fail++; $display("FAIL bp_drained: credits=%0d want 8", mult_credits); end
    endtask

    task automatic test_squash();
        do_reset();
        cdb_gnt = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            idle();
            if (c <= 2) begin req0_valid = 1'b1; req0_bmask = 4'b0010; end
            #1;
            if (c == 7) begin
                n_tests++;
                if (cdb_req !== 1'b1 || mult_credits !== 4'd6)
                    begin n_fail++; $display("FAIL squash_pre: cdb_req=%b credits=%0d want 1 6", cdb_req, mult_credits); end
            end
            tick();
        end
        idle();
        cdb_gnt = 1'b1;
        br_rec_en_1 = 1'b1; br_marker_1 = 3'd1; br_mispre_1 = 1'b1;
        #1;
        n_tests++;
        if (cdb_req !== 1'b0)
            begin n_fail++; $display("FAIL squash_same_cycle: cdb_req=%b want 0", cdb_req); end
        tick();
        for (int c = 9; c <= 11; c++) begin
            idle();
            #1;
            n_tests++;
            if (cdb_req !== 1'b0)
                begin n_fail++; $display("FAIL squash_presented c%0d: cdb_req=%b want 0", c, cdb_req); end
            if (c == 11) begin
                n_tests++;
                if (mult_credits !== 4'd8)
                    begin n_fail++; $display("FAIL squash_credits: got %0d want 8", mult_credits); end
            end
            tick();
        end
    endtask

    task automatic test_capture_resolve();
        do_reset();
        cdb_gnt = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            idle();
            if (c == 1) begin req0_valid = 1'b1; req0_bmask = 4'b0100; end
            if (c == 5) begin br_rec_en_2 = 1'b1; br_marker_2 = 3'd2; br_mispre_2 = 1'b0; end
            #1;
            tick();
        end
        idle();
        #1;
        n_tests++;
        if (cdb_req !== 1'b1 || cdb_bmask !== 4'b0000)
            begin n_fail++; $display("FAIL capture_resolve: cdb_req=%b bmask=%b want 1 0000", cdb_req, cdb_bmask); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        cdb_gnt = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            idle();
            if (c <= 5) req0_valid = 1'b1;
            #1;
            tick();
        end
        idle();
        #1;
        n_tests++;
        if (mult_credits !== 4'd3)
            begin n_fail++; $display("FAIL midrst_pre_credits: got %0d want 3", mult_credits); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int c = 0; c < 7; c++) begin
            idle();
            #1;
            n_tests++;
            if (cdb_req !== 1'b0 || mult_credits !== 4'd8)
                begin n_fail++; $display("FAIL midrst_clear c%0d: cdb_req=%b credits=%0d want 0 8", c, cdb_req, mult_credits); end
            tick();
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            idle();
            req0_valid = ($urandom_range(0, 1) == 1);
            req1_valid = ($urandom_range(0, 1) == 1);
            req0_bmask = 4'($urandom); req1_bmask = 4'($urandom);
            cdb_gnt = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 7) == 0) begin
                br_rec_en_1 = 1'b1; br_marker_1 = 3'($urandom_range(0, 3)); br_mispre_1 = ($urandom_range(0, 2) == 0);
            end
            if ($urandom_range(0, 7) == 0) begin
                br_rec_en_2 = 1'b1; br_marker_2 = 3'($urandom_range(0, 3)); br_mispre_2 = ($urandom_range(0, 2) == 0);
            end
            #1;
            expect_now();
            n_tests++;
            if (gnt0 !== e_g0 || gnt1 !== e_g1 || mult_valid !== (e_g0 | e_g1))
                begin n_fail++; $display("FAIL rand_grant c%0d: gnt=%b%b mv=%b want %b%b %b", c, gnt0, gnt1, mult_valid, e_g0, e_g1, e_g0 | e_g1); end
            n_tests++;
            if ({mult_mplier, mult_mcand, mult_dest, mult_bmask, mult_npc} !==
                (e_g1 ? {req1_mplier, req1_mcand, req1_dest, req1_bmask, req1_npc}
                      : {req0_mplier, req0_mcand, req0_dest, req0_bmask, req0_npc}))
                begin n_fail++; $display("FAIL rand_mux c%0d: mplier=%h dest=%h want gnt1=%b source", c, mult_mplier, mult_dest, e_g1); end
            n_tests++;
            if (mult_credits !== 4'(e_cred))
                begin n_fail++; $display("FAIL rand_credits c%0d: got %0d want %0d", c, mult_credits, e_cred); end
            n_tests++;
            if (cdb_req !== e_req)
                begin n_fail++; $display("FAIL rand_cdb_req c%0d: got %b want %b", c, cdb_req, e_req); end
            if (e_req) begin
                n_tests++;
                if (cdb_value !== e_val || cdb_dest !== e_dst || cdb_npc !== e_npc || cdb_bmask !== e_bm)
                    begin n_fail++; $display("FAIL rand_cdb_data c%0d: val=%h dest=%h bm=%b want %h %h %b", c, cdb_value, cdb_dest, cdb_bmask, e_val, e_dst, e_bm); end
            end
            tick();
        end
    endtask

    initial begin
        rr_m = 0;
        for (int k = 0; k < LAT; k++) pst[k] = '0;
        reset = 1'b1;
        cdb_gnt = 1'b0;
        idle();
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_squash();
        test_capture_resolve();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
